fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter in front of the shared synchronous FIFO. It lets NUM_REQ producers share one FIFO write port.

---
 rtl/fifo_wr_arbiter_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 107 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: default sizes, occupancy width helper
// and burst-lock FSM state encodings (used when FWA_BURST_LOCK_EN is defined).
package fifo_wr_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Counter must hold the value FIFO_DEPTH itself, hence depth+1.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request searched from last+1 with wrap.
// Outputs a one-hot grant (zero if no request) and its encoded index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   idx
);

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (int'(last) + k) % NUM_REQ;
            if (grant == '0 && req[j]) begin
                grant[j] = 1'b1;
                idx      = SRC_W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with credit-based FIFO occupancy tracking; 1-clk write latency.
// Optional burst lock: define FWA_BURST_LOCK_EN to add req_last and hold the grant until the last beat.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int NUM_REQ    = 4,
    parameter int AF_LEVEL   = 12,
    localparam int SRC_W     = $clog2(NUM_REQ),
    localparam int OCC_W     = occ_w(FIFO_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef FWA_BURST_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_last,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_rd_en,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [SRC_W-1:0]              fifo_wr_src,
    output logic [OCC_W-1:0]              occupancy,
    output logic                          almost_full,
    output logic                          underflow_err
);

    logic [SRC_W-1:0]   last_grant;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_grant;
    logic [SRC_W-1:0]   acc_idx;
    logic               space;
    logic               accept;
    logic               pop_ok;
    logic [OCC_W-1:0]   occ_nxt;

`ifdef FWA_BURST_LOCK_EN
    state_t state, state_nxt;

    // While locked the owner is always last_grant, so no separate owner register.
    assign eligible = (state == ST_LOCK) ? (req_valid & (NUM_REQ'(1) << last_grant)) : req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_ARB;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB:  if (accept && !req_last[acc_idx]) state_nxt = ST_LOCK;
            ST_LOCK: if (accept &&  req_last[acc_idx]) state_nxt = ST_ARB;
            default: state_nxt = ST_ARB;
        endcase
    end
`else
    assign eligible = req_valid;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) u_pick (
        .req   (eligible),
        .last  (last_grant),
        .grant (pick_grant),
        .idx   (acc_idx)
    );

    assign space       = (occupancy < OCC_W'(FIFO_DEPTH));
    assign req_ready   = (space && !reset) ? pick_grant : '0;
    assign accept      = |req_ready;
    assign almost_full = (occupancy >= OCC_W'(AF_LEVEL));

    // A pop against an empty count returns no credit; it only flags underflow.
    assign pop_ok = fifo_rd_en && (occupancy != '0);

    always_comb begin
        occ_nxt = occupancy;
        case ({accept, pop_ok})
            2'b10:   occ_nxt = occupancy + OCC_W'(1);
            2'b01:   occ_nxt = occupancy - OCC_W'(1);
            default: occ_nxt = occupancy;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr_en    <= 1'b0;
            fifo_wr_data  <= '0;
            fifo_wr_src   <= '0;
            last_grant    <= SRC_W'(NUM_REQ - 1);
            occupancy     <= '0;
            underflow_err <= 1'b0;
        end else begin
            fifo_wr_en <= accept;
            if (accept) begin
                fifo_wr_data <= req_data[int'(acc_idx)*DATA_WIDTH +: DATA_WIDTH];
                fifo_wr_src  <= acc_idx;
                last_grant   <= acc_idx;
            end
            occupancy <= occ_nxt;
            if (fifo_rd_en && occupancy == '0)
                underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (default parameters).
// Burst-lock scenario runs only when FWA_BURST_LOCK_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_rd_en;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [1:0]      fifo_wr_src;
    logic [4:0]      occupancy;
    logic            almost_full;
    logic            underflow_err;
`ifdef FWA_BURST_LOCK_EN
    logic [N-1:0]    req_last;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    fifo_wr_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
`ifdef FWA_BURST_LOCK_EN
        .req_last      (req_last),
`endif
        .req_ready     (req_ready),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_wr_src   (fifo_wr_src),
        .occupancy     (occupancy),
        .almost_full   (almost_full),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        fifo_rd_en = 1'b0;
`ifdef FWA_BURST_LOCK_EN
        req_last   = '1;
`endif
        tick();
        do_reset();

        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_data",  32'(fifo_wr_data), 32'd0);
        chk("rst_src",   32'(fifo_wr_src), 32'd0);
        chk("rst_occ",   32'(occupancy), 32'd0);
        chk("rst_uf",    32'(underflow_err), 32'd0);
        chk("rst_af",    32'(almost_full), 32'd0);

        // All four requesters valid: strict 0,1,2,3 rotation until full.
        req_valid = 4'hF;
        for (int n = 0; n < 16; n++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
            tick();
            chk("rr_wr_en", 32'(fifo_wr_en), 32'd1);
            chk("rr_src",   32'(fifo_wr_src), 32'(n % 4));
            chk("rr_data",  32'(fifo_wr_data), 32'(8'hA0 + n % 4));
            chk("rr_occ",   32'(occupancy), 32'(n + 1));
        end
        #1;
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_occ",   32'(occupancy), 32'd16);
        chk("full_af",    32'(almost_full), 32'd1);
        tick();
        chk("full_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("hold_data",  32'(fifo_wr_data), 32'hA3);

        // Pop while full: credit returns, exactly one grant (req 0) follows.
        fifo_rd_en = 1'b1;
        #1;
        chk("pop_ready", 32'(req_ready), 32'd0);
        tick();
        fifo_rd_en = 1'b0;
        chk("pop_occ", 32'(occupancy), 32'd15);
        #1;
        chk("regrant", 32'(req_ready), 32'b0001);
        tick();
        chk("regrant_occ", 32'(occupancy), 32'd16);
        chk("regrant_src", 32'(fifo_wr_src), 32'd0);
        #1;
        chk("refull_ready", 32'(req_ready), 32'd0);

        // Simultaneous accept and pop at occupancy 7, then almost_full boundary.
        req_valid = '0;
        do_reset();
        req_valid = 4'b0001;
        for (int n = 0; n < 7; n++) tick();
        chk("occ7", 32'(occupancy), 32'd7);
        fifo_rd_en = 1'b1;
        #1;
        chk("both_ready", 32'(req_ready), 32'b0001);
        tick();
        fifo_rd_en = 1'b0;
        chk("both_occ",   32'(occupancy), 32'd7);
        chk("both_wr_en", 32'(fifo_wr_en), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("af_occ", 32'(occupancy), 32'(7 + k));
            chk("af_lvl", 32'(almost_full), 32'((7 + k) >= 12));
        end

        // Underflow from reset is sticky through later traffic.
        req_valid = '0;
        do_reset();
        fifo_rd_en = 1'b1;
        tick();
        fifo_rd_en = 1'b0;
        chk("uf_set", 32'(underflow_err), 32'd1);
        chk("uf_occ", 32'(occupancy), 32'd0);
        req_valid = 4'b0010;
        #1;
        chk("uf_grant", 32'(req_ready), 32'b0010);
        tick();
        tick();
        req_valid = '0;
        chk("uf_occ2",   32'(occupancy), 32'd2);
        chk("uf_src",    32'(fifo_wr_src), 32'd1);
        chk("uf_sticky", 32'(underflow_err), 32'd1);

        // Reset asserted mid-operation with a write in flight.
        do_reset();
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) tick();
        chk("mid_wr_en", 32'(fifo_wr_en), 32'd1);
        chk("mid_occ",   32'(occupancy), 32'd5);
        reset = 1'b1;
        #1;
        chk("arst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("arst_data",  32'(fifo_wr_data), 32'd0);
        chk("arst_src",   32'(fifo_wr_src), 32'd0);
        chk("arst_occ",   32'(occupancy), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;

`ifdef FWA_BURST_LOCK_EN
        // Req 1 opens a 3-beat burst; req 0/2 stay blocked until its last beat.
        do_reset();
        req_valid = 4'b0010;
        req_last  = 4'b0101;
        #1;
        chk("lk_b1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0101;
        #1;
        chk("lk_gap", 32'(req_ready), 32'b0000);
        tick();
        req_valid = 4'b0111;
        #1;
        chk("lk_b2", 32'(req_ready), 32'b0010);
        tick();
        req_last = 4'b0111;
        #1;
        chk("lk_b3", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0101;
        #1;
        chk("lk_resume", 32'(req_ready), 32'b0100);
        tick();
        chk("lk_occ", 32'(occupancy), 32'd4);
        req_valid = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
